eth_cam_lookup_sched: RTL
=========================

# eth_cam_lookup_sched

Per-packet scheduler between the Ethernet header parser and the shared learning CAM in the learning switch output-port-lookup path. It buffers parsed headers, then sequences one lookup (destination MAC) and one learn (source MAC and source port) per packet over a single CAM request port. It delivers each lookup result to the output-port-lookup decision logic in packet order, under a valid/ready handshake.

## Interface
- NUM_IQ_BITS, 3, width of source and destination port numbers
- FIFO_DEPTH_BITS, 2, header FIFO depth is 2^FIFO_DEPTH_BITS entries
- clk  in  1  clock
- reset  in  1  synchronous, active-low (0 = reset, sampled on rising clk)
- dst_mac  in  48  parsed destination MAC, valid while eth_done=1
- src_mac  in  48  parsed source MAC, valid while eth_done=1
- src_port  in  NUM_IQ_BITS  ingress port, valid while eth_done=1
- eth_done  in  1  one-cycle pulse per parsed header
- req_valid  out  1  CAM request valid
- req_op  out  1  0 = lookup, 1 = learn
- req_mac  out  48  MAC to compare or write
- req_port  out  NUM_IQ_BITS  port to write (learn only), 0 for lookup
- req_ready  in  1  CAM accepts request when req_valid & req_ready
- resp_valid  in  1  one-cycle lookup response (never sent for learns)
- resp_hit  in  1  lookup matched
- resp_port  in  NUM_IQ_BITS  port stored with matching entry
- result_valid  out  1  lookup result valid
- result_hit  out  1  1 = unicast hit, 0 = miss or multicast (flood)
- result_port  out  NUM_IQ_BITS  destination port if hit, else 0
- result_src_port  out  NUM_IQ_BITS  ingress port of the packet
- result_ready  in  1  consumer accepts result
- hdr_drop  out  1  one-cycle pulse when a header is dropped because the FIFO is full
- drop_count  out  16  saturating count of dropped headers

## Operation
- Header FIFO entry: {dst_mac, src_mac, src_port}.
  - Push on eth_done when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Otherwise the header is dropped: hdr_drop pulses and drop_count increments, saturating at 0xFFFF.
- Pop on the result handshake (result_valid & result_ready).
- Multicast test uses bit 40 of the MAC (group bit).
- FSM states: IDLE, LOOKUP_REQ, LOOKUP_WAIT, LEARN_REQ, RESULT.
- IDLE:
  - FIFO non-empty and dst unicast -> LOOKUP_REQ.
  - FIFO non-empty and dst multicast -> LEARN_REQ, with result registered as hit=0, port=0.
- LOOKUP_REQ:
  - Drives req_valid=1, req_op=0, req_mac=head dst_mac.
  - Holds stable until req_ready, then -> LOOKUP_WAIT.
- LOOKUP_WAIT:
  - On resp_valid, capture resp_hit and resp_port, then -> LEARN_REQ.
  - If resp_hit=0, result_port is 0.
- LEARN_REQ:
  - If src_mac is unicast: drive req_valid=1, req_op=1, req_mac=head src_mac, req_port=head src_port. Hold until req_ready, then -> RESULT.
  - If src_mac is multicast: no request is issued; go directly -> RESULT.
- RESULT:
  - Drives result_valid=1 with stable fields until result_ready.
  - On handshake: pop, -> IDLE.
- Lookup always precedes the packet's own learn. The learn is issued before the result is offered.
- resp_valid outside LOOKUP_WAIT is ignored.
- At most one CAM operation is outstanding at any time.

## Timing
- Reset (reset=0 at an edge):
  - FIFO emptied; FSM -> IDLE.
  - req_valid, result_valid and hdr_drop = 0; all data outputs = 0; drop_count = 0.
  - Any in-flight CAM response after reset is ignored.
- eth_done in cycle T gives:
  - FIFO non-empty in T+1.
  - req_valid first high in T+2 (IDLE decides in T+1).
- Minimum per-packet occupancy, from IDLE to IDLE:
  - Single-cycle CAM (ready always 1, resp 1 cycle after accept), result_ready=1: IDLE, LOOKUP_REQ, LOOKUP_WAIT, LEARN_REQ, RESULT = 5 cycles.
  - With the FIFO fed continuously, the block is back-to-back at 5 cycles per packet.
- hdr_drop asserts in the cycle after the rejected eth_done.
- drop_count updates on the same edge that hdr_drop asserts.
- All outputs are registered. No combinational path from any input to any output.

## Test plan
- Single packet:
  - Stimulus: dst 00:11:22:33:44:55, src 00:aa:bb:cc:dd:ee, port 2; CAM returns hit, port 5.
  - Required: lookup req at T+2; learn req with mac 00:aa:bb:cc:dd:ee, port 2; result hit=1, port=5, src_port=2.
- Multicast:
  - Stimulus: dst ff:ff:ff:ff:ff:ff.
  - Required: no lookup request; learn issued; result hit=0, port=0.
- Backpressure:
  - Stimulus: req_ready low 3 cycles, then result_ready low 4 cycles.
  - Required: req and result fields held stable throughout; exactly one accept each.
- Overflow (FIFO_DEPTH_BITS=2):
  - Stimulus: 6 eth_done pulses back-to-back with result_ready=0.
  - Required: 4 headers accepted (1 at head of FIFO, 3 queued), hdr_drop pulses twice, drop_count=2; results then emerge in order.
- Reset mid-operation:
  - Stimulus: assert reset in LOOKUP_WAIT, then send a stray resp_valid after release.
  - Required: all outputs 0, FSM idle, stray response ignored, next packet handled normally.

Source files
------------

// File: rtl/eth_cam_lookup_sched_if.sv
// CAM request/response port shared between the lookup scheduler (master)
// and the learning CAM (slave). One operation in flight at a time; lookups
// get a one-cycle response, learns get none.
interface eth_cam_lookup_sched_if #(
  parameter int NUM_IQ_BITS = 3
) ();
  logic                   req_valid;
  logic                   req_op;      // 0 = lookup, 1 = learn
  logic [47:0]            req_mac;
  logic [NUM_IQ_BITS-1:0] req_port;
  logic                   req_ready;
  logic                   resp_valid;
  logic                   resp_hit;
  logic [NUM_IQ_BITS-1:0] resp_port;

  modport master (
    output req_valid, req_op, req_mac, req_port,
    input  req_ready, resp_valid, resp_hit, resp_port
  );

  modport slave (
    input  req_valid, req_op, req_mac, req_port,
    output req_ready, resp_valid, resp_hit, resp_port
  );
endinterface

// File: rtl/eth_cam_lookup_sched.sv
// Per-packet CAM scheduler for the learning switch lookup path.
// Parsed headers are queued; for each one the block issues a destination
// lookup (skipped for group addresses) then a source learn (skipped for
// group sources), and finally presents the lookup result in packet order.
// Every output comes straight from a flop.
module eth_cam_lookup_sched #(
  parameter int NUM_IQ_BITS     = 3,
  parameter int FIFO_DEPTH_BITS = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [47:0]            dst_mac,
  input  logic [47:0]            src_mac,
  input  logic [NUM_IQ_BITS-1:0] src_port,
  input  logic                   eth_done,
  eth_cam_lookup_sched_if.master cam,
  output logic                   result_valid,
  output logic                   result_hit,
  output logic [NUM_IQ_BITS-1:0] result_port,
  output logic [NUM_IQ_BITS-1:0] result_src_port,
  input  logic                   result_ready,
  output logic                   hdr_drop,
  output logic [15:0]            drop_count
);

  localparam int DEPTH     = 1 << FIFO_DEPTH_BITS;
  localparam int GROUP_BIT = 40;  // I/G bit: LSB of the first octet on the wire

  typedef struct packed {
    logic [47:0]            dst;
    logic [47:0]            src;
    logic [NUM_IQ_BITS-1:0] port;
  } hdr_t;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP_REQ,
    LOOKUP_WAIT,
    LEARN_REQ,
    RESULT
  } state_t;

  // Header FIFO
  hdr_t                     mem_q [DEPTH];
  hdr_t                     head;
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_BITS:0]   count_q, count_d;
  logic                     fifo_full, fifo_empty;
  logic                     push, pop, drop;

  // Drop reporting
  logic        hdr_drop_q, hdr_drop_d;
  logic [15:0] drop_count_q, drop_count_d;

  // Scheduler FSM and registered outputs
  state_t                 state_q, state_d;
  logic                   enter_learn;
  logic                   req_valid_q, req_valid_d;
  logic                   req_op_q, req_op_d;
  logic [47:0]            req_mac_q, req_mac_d;
  logic [NUM_IQ_BITS-1:0] req_port_q, req_port_d;
  logic                   result_valid_q, result_valid_d;
  logic                   result_hit_q, result_hit_d;
  logic [NUM_IQ_BITS-1:0] result_port_q, result_port_d;
  logic [NUM_IQ_BITS-1:0] result_src_port_q, result_src_port_d;

  assign head       = mem_q[rd_ptr_q];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (FIFO_DEPTH_BITS + 1)'(DEPTH));
  // The head entry stays in the FIFO until its result is consumed, so a
  // full FIFO can still take a new header in the cycle the head leaves.
  assign pop        = result_valid_q & result_ready;
  assign push       = eth_done & (~fifo_full | pop);
  assign drop       = eth_done & ~push;

  // FIFO pointer/occupancy and drop counter next-state
  always_comb begin : fifo_comb
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    hdr_drop_d   = drop;
    drop_count_d = drop_count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (drop && drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
  end

  // Header storage write port
  always_ff @(posedge clk) begin : fifo_mem
    // NOTE: the storage array has no reset; emptiness is tracked by the
    // pointers and count, so clearing the entries would only add logic.
    if (push) mem_q[wr_ptr_q] <= '{dst: dst_mac, src: src_mac, port: src_port};
  end

  // Scheduler next-state and next-output logic
  always_comb begin : fsm_comb
    // NOTE: every signal written here is defaulted first, so no branch of
    // the case statement can leave one unassigned and infer a latch.
    state_d           = state_q;
    enter_learn       = 1'b0;
    req_valid_d       = req_valid_q;
    req_op_d          = req_op_q;
    req_mac_d         = req_mac_q;
    req_port_d        = req_port_q;
    result_valid_d    = result_valid_q;
    result_hit_d      = result_hit_q;
    result_port_d     = result_port_q;
    result_src_port_d = result_src_port_q;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          result_src_port_d = head.port;
          if (head.dst[GROUP_BIT]) begin
            // Group destination: flood, no lookup needed.
            result_hit_d  = 1'b0;
            result_port_d = '0;
            enter_learn   = 1'b1;
            state_d       = LEARN_REQ;
          end else begin
            req_valid_d = 1'b1;
            req_op_d    = 1'b0;
            req_mac_d   = head.dst;
            req_port_d  = '0;
            state_d     = LOOKUP_REQ;
          end
        end
      end
      LOOKUP_REQ: begin
        if (cam.req_ready) begin
          req_valid_d = 1'b0;
          state_d     = LOOKUP_WAIT;
        end
      end
      LOOKUP_WAIT: begin
        if (cam.resp_valid) begin
          result_hit_d  = cam.resp_hit;
          result_port_d = cam.resp_hit ? cam.resp_port : '0;
          enter_learn   = 1'b1;
          state_d       = LEARN_REQ;
        end
      end
      LEARN_REQ: begin
        // req_valid_q low here means the source was a group address and
        // the learn was skipped on entry.
        if (!req_valid_q || cam.req_ready) begin
          req_valid_d    = 1'b0;
          result_valid_d = 1'b1;
          state_d        = RESULT;
        end
      end
      RESULT: begin
        if (result_ready) begin
          result_valid_d = 1'b0;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Learn request is launched on entry to LEARN_REQ so req_valid is a flop.
    if (enter_learn && !head.src[GROUP_BIT]) begin
      req_valid_d = 1'b1;
      req_op_d    = 1'b1;
      req_mac_d   = head.src;
      req_port_d  = head.port;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin : regs
    // NOTE: non-blocking assignments here so every flop samples the
    // pre-edge value of every other flop, independent of statement order.
    if (!reset) begin
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      count_q           <= '0;
      hdr_drop_q        <= 1'b0;
      drop_count_q      <= '0;
      state_q           <= IDLE;
      req_valid_q       <= 1'b0;
      req_op_q          <= 1'b0;
      req_mac_q         <= '0;
      req_port_q        <= '0;
      result_valid_q    <= 1'b0;
      result_hit_q      <= 1'b0;
      result_port_q     <= '0;
      result_src_port_q <= '0;
    end else begin
      wr_ptr_q          <= wr_ptr_d;
      rd_ptr_q          <= rd_ptr_d;
      count_q           <= count_d;
      hdr_drop_q        <= hdr_drop_d;
      drop_count_q      <= drop_count_d;
      state_q           <= state_d;
      req_valid_q       <= req_valid_d;
      req_op_q          <= req_op_d;
      req_mac_q         <= req_mac_d;
      req_port_q        <= req_port_d;
      result_valid_q    <= result_valid_d;
      result_hit_q      <= result_hit_d;
      result_port_q     <= result_port_d;
      result_src_port_q <= result_src_port_d;
    end
  end

  assign cam.req_valid   = req_valid_q;
  assign cam.req_op      = req_op_q;
  assign cam.req_mac     = req_mac_q;
  assign cam.req_port    = req_port_q;
  assign result_valid    = result_valid_q;
  assign result_hit      = result_hit_q;
  assign result_port     = result_port_q;
  assign result_src_port = result_src_port_q;
  assign hdr_drop        = hdr_drop_q;
  assign drop_count      = drop_count_q;

endmodule
